// File: rtl/addr_xlate_unit.sv
`default_nettype none
// ============================================================================
// Module   : addr_xlate_unit
// Purpose  : Local-to-global address translation and routing of CPU requests
//            to local memory or the NoC. Optional macro: ADDR_XLATE_FAULT_EN
//            (range/overflow fault response instead of issuing).
// Revision : 1.0 - initial release
// ============================================================================
module addr_xlate_unit #(
  parameter int NODE_BITS   = 4,
  parameter int WINDOW_BITS = 10,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NODE_BITS-1:0]  i_node_address,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_loc_valid,
  input  logic                  i_loc_ready,
  output logic                  o_noc_valid,
  input  logic                  i_noc_ready,
  output logic                  o_out_write,
  output logic [ADDR_WIDTH-1:0] o_out_addr,
  output logic [31:0]           o_out_wdata,
  output logic [NODE_BITS-1:0]  o_out_dest,
  input  logic                  i_loc_rvalid,
  input  logic [31:0]           i_loc_rdata,
  input  logic                  i_noc_rvalid,
  input  logic [31:0]           i_noc_rdata,
  output logic                  o_resp_valid,
  output logic [31:0]           o_resp_rdata,
  output logic                  o_resp_fault,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE_LOC = 3'd1,
    S_ISSUE_NOC = 3'd2,
    S_WAIT_LOC  = 3'd3,
    S_WAIT_NOC  = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_loc_valid;
  logic                  r_noc_valid;
  logic                  r_out_write;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [31:0]           r_out_wdata;
  logic [NODE_BITS-1:0]  r_out_dest;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic                  r_resp_fault;

  logic [ADDR_WIDTH-1:0] w_node_base;
  logic [ADDR_WIDTH-1:0] w_global;
  logic [NODE_BITS-1:0]  w_dest;
  logic                  w_fault;

  assign w_node_base = {{(ADDR_WIDTH-NODE_BITS){1'b0}}, i_node_address} << WINDOW_BITS;

`ifdef ADDR_XLATE_FAULT_EN
  // One extra bit catches wrap-around of the base+offset addition.
  logic [ADDR_WIDTH:0] w_sum;
  assign w_sum    = {1'b0, w_node_base} + {1'b0, i_req_addr};
  assign w_global = w_sum[ADDR_WIDTH-1:0];
  assign w_fault  = w_sum[ADDR_WIDTH] | (|(w_global >> (WINDOW_BITS + NODE_BITS)));
`else
  assign w_global = w_node_base + i_req_addr;
  assign w_fault  = 1'b0;
`endif

  assign w_dest = w_global[WINDOW_BITS+NODE_BITS-1:WINDOW_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_loc_valid  <= 1'b0;
      r_noc_valid  <= 1'b0;
      r_out_write  <= 1'b0;
      r_out_addr   <= '0;
      r_out_wdata  <= '0;
      r_out_dest   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_out_write <= i_req_write;
            r_out_addr  <= w_global;
            r_out_wdata <= i_req_wdata;
            r_out_dest  <= w_dest;
            if (w_fault) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= '0;
            end else if (w_dest == i_node_address) begin
              r_state     <= S_ISSUE_LOC;
              r_loc_valid <= 1'b1;
            end else begin
              r_state     <= S_ISSUE_NOC;
              r_noc_valid <= 1'b1;
            end
          end
        end
        S_ISSUE_LOC: begin
          if (i_loc_ready) begin
            r_loc_valid <= 1'b0;
            r_state     <= S_WAIT_LOC;
          end
        end
        S_ISSUE_NOC: begin
          if (i_noc_ready) begin
            r_noc_valid <= 1'b0;
            r_state     <= S_WAIT_NOC;
          end
        end
        S_WAIT_LOC: begin
          if (i_loc_rvalid) begin
            r_resp_rdata <= i_loc_rdata;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_WAIT_NOC: begin
          if (i_noc_rvalid) begin
            r_resp_rdata <= i_noc_rdata;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_loc_valid  = r_loc_valid;
  assign o_noc_valid  = r_noc_valid;
  assign o_out_write  = r_out_write;
  assign o_out_addr   = r_out_addr;
  assign o_out_wdata  = r_out_wdata;
  assign o_out_dest   = r_out_dest;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_addr_xlate_unit.sv
`default_nettype none
// Testbench for addr_xlate_unit: directed vector table, reset/stray-completion
// sequences and randomized requests against an arithmetic reference model.
module tb_addr_xlate_unit;

`ifdef ADDR_XLATE_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  node;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        loc_valid, loc_ready, noc_valid, noc_ready;
  logic        out_write;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_dest;
  logic        loc_rvalid, noc_rvalid;
  logic [31:0] loc_rdata, noc_rdata;
  logic        resp_valid, resp_fault, busy;
  logic [31:0] resp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addr_xlate_unit #(.NODE_BITS(4), .WINDOW_BITS(10), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_node_address(node),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_loc_valid(loc_valid), .i_loc_ready(loc_ready),
    .o_noc_valid(noc_valid), .i_noc_ready(noc_ready),
    .o_out_write(out_write), .o_out_addr(out_addr), .o_out_wdata(out_wdata),
    .o_out_dest(out_dest),
    .i_loc_rvalid(loc_rvalid), .i_loc_rdata(loc_rdata),
    .i_noc_rvalid(noc_rvalid), .i_noc_rdata(noc_rdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_resp_fault(resp_fault), .o_busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // port: 0 = local, 1 = NoC, 2 = fault response
  typedef struct {
    logic [3:0]  node;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          rdy;
    int          rv;
    int          port;
    logic [31:0] eaddr;
    logic [3:0]  edest;
  } vec_t;

  // Reference: global = node*window + addr, fault on high bits or 32-bit wrap.
  task automatic model(input logic [3:0] nd, input logic [31:0] ad,
                       output int port, output logic [31:0] ga, output logic [3:0] dest);
    longint unsigned s;
    bit flt;
    s    = longint'(nd) * 64'd1024 + longint'(ad);
    ga   = 32'(s % 64'h1_0000_0000);
    dest = 4'((ga / 1024) % 16);
    flt  = ((ga / 16384) != 0) || (s >= 64'h1_0000_0000);
    if (FAULT_EN && flt) port = 2;
    else if (dest == nd) port = 0;
    else port = 1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    bit is_loc;
    is_loc = (v.port == 0);
    @(negedge clk);
    chk({tag, " req_ready idle"}, req_ready, 1);
    node = v.node; req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wd;
    loc_ready = 1'b0; noc_ready = 1'b0; loc_rvalid = 1'b0; noc_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (v.port == 2) begin
      chk({tag, " fault resp_valid"}, resp_valid, 1);
      chk({tag, " fault flag"}, resp_fault, 1);
      chk({tag, " fault rdata"}, resp_rdata, 0);
      chk({tag, " fault no issue"}, {loc_valid, noc_valid}, 0);
      @(negedge clk);
      chk({tag, " fault resp one cycle"}, resp_valid, 0);
      chk({tag, " fault back idle"}, req_ready, 1);
      return;
    end
    for (int i = 0; i <= v.rdy; i++) begin
      chk({tag, " loc_valid"}, loc_valid, is_loc);
      chk({tag, " noc_valid"}, noc_valid, !is_loc);
      chk({tag, " out_addr"}, out_addr, v.eaddr);
      chk({tag, " out_dest"}, out_dest, v.edest);
      chk({tag, " out_write"}, out_write, v.wr);
      chk({tag, " out_wdata"}, out_wdata, v.wd);
      chk({tag, " req_ready issue"}, req_ready, 0);
      // Completions seen during issue (including the handshake cycle) are ignored.
      loc_rvalid = 1'b1; noc_rvalid = 1'b1; loc_rdata = 32'hBAD0_0001; noc_rdata = 32'hBAD0_0002;
      if (i == v.rdy) begin
        if (is_loc) loc_ready = 1'b1; else noc_ready = 1'b1;
      end
      @(negedge clk);
      loc_rvalid = 1'b0; noc_rvalid = 1'b0;
    end
    loc_ready = 1'b0; noc_ready = 1'b0;
    chk({tag, " valid dropped"}, {loc_valid, noc_valid}, 0);
    chk({tag, " busy wait"}, busy, 1);
    for (int i = 0; i < v.rv; i++) begin
      if (is_loc) begin noc_rvalid = 1'b1; noc_rdata = 32'hBAD0_0003; end
      else        begin loc_rvalid = 1'b1; loc_rdata = 32'hBAD0_0004; end
      @(negedge clk);
      loc_rvalid = 1'b0; noc_rvalid = 1'b0;
      chk({tag, " no early resp"}, resp_valid, 0);
    end
    if (is_loc) begin loc_rvalid = 1'b1; loc_rdata = v.rd; end
    else        begin noc_rvalid = 1'b1; noc_rdata = v.rd; end
    @(negedge clk);
    loc_rvalid = 1'b0; noc_rvalid = 1'b0;
    chk({tag, " resp_valid"}, resp_valid, 1);
    chk({tag, " resp_fault"}, resp_fault, 0);
    if (!v.wr) chk({tag, " resp_rdata"}, resp_rdata, v.rd);
    chk({tag, " req_ready resp"}, req_ready, 0);
    @(negedge clk);
    chk({tag, " resp one cycle"}, resp_valid, 0);
    chk({tag, " busy clear"}, busy, 0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    rst_n = 1'b0; node = '0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    loc_ready = 1'b0; noc_ready = 1'b0; loc_rvalid = 1'b0; noc_rvalid = 1'b0;
    loc_rdata = '0; noc_rdata = '0;

    tbl[0] = '{4'h5, 1'b0, 32'd10,         32'h0,       32'hCAFE,   0, 0, 0, 32'd5130,   4'd5};
    tbl[1] = '{4'h0, 1'b1, 32'd1034,       32'h1234,    32'h0,      0, 2, 1, 32'd1034,   4'd1};
    tbl[2] = '{4'h2, 1'b0, 32'd1031,       32'h0,       32'h7777,   3, 1, 1, 32'd3079,   4'd3};
    tbl[3] = '{4'h0, 1'b0, 32'h4000,       32'h0,       32'h4444,   0, 0, FAULT_EN ? 2 : 0, 32'h4000, 4'd0};
    tbl[4] = '{4'hF, 1'b0, 32'hFFFF_FC00,  32'h0,       32'h9999,   1, 0, FAULT_EN ? 2 : 1, 32'h3800, 4'd14};
    tbl[5] = '{4'h7, 1'b0, 32'd1023,       32'h0,       32'hA5A5,   1, 1, 0, 32'd8191,   4'd7};
    tbl[6] = '{4'h7, 1'b1, 32'd1024,       32'hFEED,    32'h0,      2, 0, 1, 32'd8192,   4'd8};
    tbl[7] = '{4'hF, 1'b0, 32'd0,          32'h0,       32'h1357,   0, 3, 0, 32'h3C00,   4'd15};

    repeat (2) @(negedge clk);
    chk("reset loc_valid", loc_valid, 0);
    chk("reset noc_valid", noc_valid, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_addr", out_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", req_ready, 1);

    // Stray completion while idle
    loc_rvalid = 1'b1; loc_rdata = 32'hDEAD;
    @(negedge clk);
    loc_rvalid = 1'b0;
    chk("idle stray busy", busy, 0);
    chk("idle stray resp", resp_valid, 0);
    @(negedge clk);
    chk("idle stray resp2", resp_valid, 0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset during WAIT_NOC, then a late completion for the abandoned request
    @(negedge clk);
    node = 4'h0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd1034; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0; noc_ready = 1'b1;
    chk("rst seq noc_valid", noc_valid, 1);
    @(negedge clk);
    noc_ready = 1'b0;
    chk("rst seq busy wait", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst out_addr", out_addr, 0);
    chk("async rst out_dest", out_dest, 0);
    chk("async rst resp_rdata", resp_rdata, 0);
    chk("async rst valids", {loc_valid, noc_valid, resp_valid, resp_fault}, 0);
    @(negedge clk);
    rst_n = 1'b1; noc_rvalid = 1'b1; noc_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    noc_rvalid = 1'b0;
    chk("late rvalid resp", resp_valid, 0);
    chk("late rvalid ready", req_ready, 1);
    @(negedge clk);
    chk("late rvalid resp2", resp_valid, 0);

    for (int i = 0; i < 40; i++) begin
      v.node = 4'($urandom_range(0, 15));
      v.wr   = 1'($urandom_range(0, 1));
      v.addr = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 16383));
      v.wd   = $urandom;
      v.rd   = $urandom;
      v.rdy  = $urandom_range(0, 3);
      v.rv   = $urandom_range(0, 3);
      model(v.node, v.addr, v.port, v.eaddr, v.edest);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addr_xlate_unit.md
ADDR_XLATE_UNIT -- requirements
Module: addr_xlate_unit

Interface
REQ-001 SHALL have parameter NODE_BITS, default 4, node-ID width ({x,y}, 2 bits each).
REQ-002 SHALL have parameter WINDOW_BITS, default 10, log2 of per-node memory window (1024 locations).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, width of local and global addresses.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 NODEADDRESS  input  NODE_BITS  ID of this node, static after reset.
REQ-007 REQ_VALID / REQ_READY  input / output  1 / 1  CPU request handshake.
REQ-008 REQ_WRITE, REQ_ADDR, REQ_WDATA  input  1, ADDR_WIDTH, 32  request type, local address, write data.
REQ-009 LOC_VALID / LOC_READY  output / input  1 / 1  issue to local memory.
REQ-010 NOC_VALID / NOC_READY  output / input  1 / 1  issue to NoC.
REQ-011 OUT_WRITE, OUT_ADDR, OUT_WDATA, OUT_DEST  output  1, ADDR_WIDTH, 32, NODE_BITS  registered fields shared by both issue ports.
REQ-012 LOC_RVALID, LOC_RDATA / NOC_RVALID, NOC_RDATA  input  1, 32  completion (read data or write ack) per port.
REQ-013 RESP_VALID, RESP_RDATA, RESP_FAULT, BUSY  output  1, 32, 1, 1  CPU response, fault flag, FSM not IDLE.

Function
REQ-014 Global address SHALL be (NODEADDRESS << WINDOW_BITS) + REQ_ADDR, modulo 2^ADDR_WIDTH.
REQ-015 Destination node SHALL be global[WINDOW_BITS+NODE_BITS-1:WINDOW_BITS]; equal to NODEADDRESS -> local, else remote.
REQ-016 FSM states SHALL be IDLE, ISSUE_LOC, ISSUE_NOC, WAIT_LOC, WAIT_NOC, RESP.
REQ-017 REQ_READY SHALL be 1 only in IDLE; acceptance = REQ_VALID & REQ_READY on a rising edge, latching global address, dest, write, wdata.
REQ-018 IDLE -> ISSUE_LOC or ISSUE_NOC on acceptance; valid output asserted the cycle after acceptance.
REQ-019 ISSUE_x SHALL hold x_VALID and all OUT_* stable until x_READY; transition to WAIT_x on handshake.
REQ-020 WAIT_x -> RESP on x_RVALID, latching x_RDATA (writes: RDATA latched but don't-care); RVALID of the non-selected port ignored.
REQ-021 RESP SHALL assert RESP_VALID for exactly one cycle, then return to IDLE; no new acceptance during RESP.
REQ-022 RVALID in the same cycle as x_READY SHALL be ignored (completion counted only from WAIT_x).
REQ-023 RVALID on any port while IDLE or ISSUE_x SHALL be ignored.
REQ-024 Minimum latency: accept (cycle 0), valid (1), ready same cycle, RVALID (2), RESP_VALID (3).
REQ-025 BUSY SHALL equal (state != IDLE).

Reset
REQ-026 RESET low SHALL immediately force IDLE, REQ_READY=1 after release, LOC_VALID=NOC_VALID=RESP_VALID=RESP_FAULT=BUSY=0, OUT_*=0, RESP_RDATA=0.
REQ-027 Reset mid-transaction SHALL abandon it; a later RVALID for it SHALL be ignored.

Configuration
REQ-028 Macro ADDR_XLATE_FAULT_EN defined: if global >> (WINDOW_BITS+NODE_BITS) is nonzero, or the addition overflows ADDR_WIDTH, request SHALL go IDLE -> RESP with RESP_FAULT=1, RESP_RDATA=0, no issue on either port.
REQ-029 Macro undefined: no range check, RESP_FAULT tied 0, out-of-range addresses issued per REQ-015 with untruncated OUT_ADDR.

Verification
REQ-030 NODEADDRESS=4'b0101, read REQ_ADDR=10, LOC_READY=1, LOC_RVALID+RDATA=32'hCAFE next cycle -> LOC_VALID, OUT_ADDR=5130, OUT_DEST=5, RESP_VALID with RESP_RDATA=32'hCAFE at cycle 3.
REQ-031 NODEADDRESS=0, write REQ_ADDR=1034 -> NOC_VALID, OUT_DEST=1, OUT_ADDR=1034, LOC_VALID never 1; RESP_VALID one cycle after NOC_RVALID.
REQ-032 NOC_READY low 3 cycles -> NOC_VALID and OUT_* stable for 4 cycles, REQ_READY=0 throughout, single handshake.
REQ-033 NODEADDRESS=0, REQ_ADDR=32'h4000 -> with ADDR_XLATE_FAULT_EN: RESP_VALID=1, RESP_FAULT=1 at cycle 1, no issue; without: LOC_VALID, OUT_ADDR=32'h4000.
REQ-034 RESET low during WAIT_NOC, then NOC_RVALID after release -> all outputs per REQ-026, no RESP_VALID.
REQ-035 LOC_RVALID pulsed while IDLE and during WAIT_NOC -> no state change, no RESP_VALID.
